// File: rtl/pulse_width_meter.sv
// Measures the width, in clk cycles, of one armed high pulse on a synchronous input.
// The counter saturates at all-ones; ovf reports that saturation for the last completed pulse.
module pulse_width_meter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             arm,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    MEAS  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic             sat, sat_n;
  logic [WIDTH-1:0] q_n;
  logic             ovf_n;
  logic             done_n;
  logic             sig_d;
  logic             rise;

  // sig_d resets high so a sig already high at reset release is not an edge.
  assign rise = sig & ~sig_d;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sat   <= 1'b0;
      q     <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
      sig_d <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sat   <= sat_n;
      q     <= q_n;
      ovf   <= ovf_n;
      done  <= done_n;
      sig_d <= sig;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sat_n   = sat;
    q_n     = q;
    ovf_n   = ovf;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        // abort has no meaning here, so arm wins even when both are high.
        if (arm) state_n = ARMED;
      end
      ARMED: begin
        if (abort) begin
          state_n = IDLE;
        end else if (rise) begin
          state_n = MEAS;
          cnt_n   = WIDTH'(1);
          sat_n   = 1'b0;
        end
      end
      MEAS: begin
        if (abort) begin
          state_n = IDLE;
        end else if (sig) begin
          if (&cnt) sat_n = 1'b1;
          else      cnt_n = cnt + WIDTH'(1);
        end else begin
          state_n = IDLE;
          q_n     = cnt;
          ovf_n   = sat;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
